// File: rtl/iob_uart16550_init_pkg.sv
// Shared constants, state encoding and init-write payload for the UART16550 init sequencer.
package iob_uart16550_init_pkg;

    localparam logic [2:0] RBR_THR_DLL = 3'd0;
    localparam logic [2:0] IER_DLM     = 3'd1;
    localparam logic [2:0] IIR_FCR     = 3'd2;
    localparam logic [2:0] LCR         = 3'd3;

    localparam logic [7:0] LCR_DLAB = 8'h83;
    localparam logic [7:0] FCR_INIT = 8'h07;

    localparam int unsigned NSTEPS = 6;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned TMO_W  = 8;

    typedef enum logic [1:0] {ISSUE, WAIT, PASS, PEND} seq_state_e;

    typedef struct packed {
        logic [2:0] adr;
        logic [7:0] dat;
    } init_wr_t;

endpackage

// File: rtl/iob_uart16550_init_rom.sv
// Step index to 16550 register write (address, data) for the init sequence.
module iob_uart16550_init_rom
    import iob_uart16550_init_pkg::*;
#(
    parameter logic [7:0] LCR_INIT = 8'h03,
    parameter logic [7:0] IER_INIT = 8'h01
) (
    input  logic [STEP_W-1:0] step,
    input  logic [15:0]       div,
    output init_wr_t          wr_c
);

    // DLAB is opened first so the divisor lands in DLL/DLM, then LCR closes it.
    always_comb begin
        wr_c = '0;
        case (step)
            3'd0:    begin wr_c.adr = LCR;         wr_c.dat = LCR_DLAB;   end
            3'd1:    begin wr_c.adr = RBR_THR_DLL; wr_c.dat = div[7:0];   end
            3'd2:    begin wr_c.adr = IER_DLM;     wr_c.dat = div[15:8];  end
            3'd3:    begin wr_c.adr = LCR;         wr_c.dat = LCR_INIT;   end
            3'd4:    begin wr_c.adr = IIR_FCR;     wr_c.dat = FCR_INIT;   end
            3'd5:    begin wr_c.adr = IER_DLM;     wr_c.dat = IER_INIT;   end
            default: wr_c = '0;
        endcase
    end

endmodule

// File: rtl/iob_uart16550_init_seq.sv
// UART16550 boot/reconfig write sequencer and Wishbone master mux in front of uart_top.
// Optional ack timeout: define UART_INIT_ACK_TIMEOUT_EN.
module iob_uart16550_init_seq
    import iob_uart16550_init_pkg::*;
#(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned DATA_W   = 8,
    parameter logic [15:0] DIV_INIT = 16'd27,
    parameter logic [7:0]  LCR_INIT = 8'h03,
    parameter logic [7:0]  IER_INIT = 8'h01
`ifdef UART_INIT_ACK_TIMEOUT_EN
    ,
    parameter int unsigned ACK_TMO  = 255
`endif
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cfg_start_i,
    input  logic [15:0]       div_i,
    output logic              busy_o,
    output logic              err_o,
    input  logic [ADDR_W-1:0] h_adr_i,
    input  logic [DATA_W-1:0] h_dat_i,
    input  logic              h_sel_i,
    input  logic              h_we_i,
    input  logic              h_cyc_i,
    input  logic              h_stb_i,
    output logic              h_ack_o,
    output logic [DATA_W-1:0] h_dat_o,
    output logic [ADDR_W-1:0] u_adr_o,
    output logic [DATA_W-1:0] u_dat_o,
    output logic              u_sel_o,
    output logic              u_we_o,
    output logic              u_cyc_o,
    output logic              u_stb_o,
    input  logic              u_ack_i,
    input  logic [DATA_W-1:0] u_dat_i
);

    seq_state_e        state;
    logic [STEP_W-1:0] step;
    logic [15:0]       div_q;
    logic              seq_cyc;
    logic [ADDR_W-1:0] seq_adr;
    logic [DATA_W-1:0] seq_dat;
    init_wr_t          rom_wr;
    logic              host_own;

    iob_uart16550_init_rom #(
        .LCR_INIT (LCR_INIT),
        .IER_INIT (IER_INIT)
    ) u_rom (
        .step (step),
        .div  (div_q),
        .wr_c (rom_wr)
    );

`ifdef UART_INIT_ACK_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Sequencer: one write per ISSUE/WAIT pair, bus dropped for a cycle after each ack.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state   <= ISSUE;
            step    <= '0;
            div_q   <= DIV_INIT;
            seq_cyc <= 1'b0;
            seq_adr <= '0;
            seq_dat <= '0;
`ifdef UART_INIT_ACK_TIMEOUT_EN
            tmo_cnt <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ISSUE: begin
                    seq_cyc <= 1'b1;
                    seq_adr <= ADDR_W'(rom_wr.adr);
                    seq_dat <= DATA_W'(rom_wr.dat);
                    state   <= WAIT;
`ifdef UART_INIT_ACK_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (u_ack_i) begin
                        seq_cyc <= 1'b0;
                        seq_adr <= '0;
                        seq_dat <= '0;
                        if (step == STEP_W'(NSTEPS - 1)) begin
                            step  <= '0;
                            state <= PASS;
                        end else begin
                            step  <= step + STEP_W'(1);
                            state <= ISSUE;
                        end
                    end
`ifdef UART_INIT_ACK_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(ACK_TMO - 1)) begin
                        // Slave never answered: abandon the sequence and free the bus.
                        seq_cyc <= 1'b0;
                        seq_adr <= '0;
                        seq_dat <= '0;
                        err_q   <= 1'b1;
                        step    <= '0;
                        state   <= PASS;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                PASS: begin
                    if (cfg_start_i) begin
                        div_q <= div_i;
                        step  <= '0;
                        state <= h_cyc_i ? PEND : ISSUE;
`ifdef UART_INIT_ACK_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                PEND: begin
                    if (!h_cyc_i) begin
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

    // Host owns the UART port only in PASS/PEND; otherwise its request is stalled.
    assign host_own = (state == PASS) || (state == PEND);
    assign busy_o   = (state != PASS);

    assign u_cyc_o = host_own ? h_cyc_i : seq_cyc;
    assign u_stb_o = host_own ? h_stb_i : seq_cyc;
    assign u_we_o  = host_own ? h_we_i  : seq_cyc;
    assign u_sel_o = host_own ? h_sel_i : seq_cyc;
    assign u_adr_o = host_own ? h_adr_i : seq_adr;
    assign u_dat_o = host_own ? h_dat_i : seq_dat;

    assign h_ack_o = host_own & u_ack_i;
    assign h_dat_o = host_own ? u_dat_i : '0;

endmodule

// File: tb/tb_iob_uart16550_init_seq.sv
// Bench for iob_uart16550_init_seq: behavioural UART slave, write log and expected-sequence model.
module tb_iob_uart16550_init_seq;

    logic        clk, arst_n, cfg_start;
    logic [15:0] div;
    logic        busy, err;
    logic [2:0]  h_adr;
    logic [7:0]  h_dat, h_rdat;
    logic        h_sel, h_we, h_cyc, h_stb, h_ack;
    logic [2:0]  u_adr;
    logic [7:0]  u_dat, u_rdat;
    logic        u_sel, u_we, u_cyc, u_stb, u_ack;

    int          vectors, miscompares;
    int          ack_dly, wcnt;
    bit          suppress;
    logic [10:0] wlog[$];

    typedef struct {
        logic [15:0] div;
        int          dly;
        int          cyc;
    } cfg_vec_t;

    typedef struct {
        logic [2:0] adr;
        logic       we;
        logic [7:0] wdat;
        logic [7:0] rexp;
    } host_vec_t;

    cfg_vec_t  cfg_tab[4];
    host_vec_t host_tab[5];

    iob_uart16550_init_seq dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .cfg_start_i (cfg_start),
        .div_i       (div),
        .busy_o      (busy),
        .err_o       (err),
        .h_adr_i     (h_adr),
        .h_dat_i     (h_dat),
        .h_sel_i     (h_sel),
        .h_we_i      (h_we),
        .h_cyc_i     (h_cyc),
        .h_stb_i     (h_stb),
        .h_ack_o     (h_ack),
        .h_dat_o     (h_rdat),
        .u_adr_o     (u_adr),
        .u_dat_o     (u_dat),
        .u_sel_o     (u_sel),
        .u_we_o      (u_we),
        .u_cyc_o     (u_cyc),
        .u_stb_o     (u_stb),
        .u_ack_i     (u_ack),
        .u_dat_i     (u_rdat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read data of the stand-in UART: LSR (index 5) idle value, other indices a fixed pattern.
    function automatic logic [7:0] uart_rd(input logic [2:0] a);
        return (a == 3'd5) ? 8'h60 : (8'hA0 | {5'd0, a});
    endfunction

    assign u_rdat = uart_rd(u_adr);

    // Stand-in uart_top: registered ack ack_dly cycles after stb; writes are logged on ack.
    always @(posedge clk) begin
        if (u_cyc && u_stb && !u_ack && !suppress) begin
            if (wcnt + 1 >= ack_dly) begin
                u_ack <= 1'b1;
                wcnt  <= 0;
                if (u_we) wlog.push_back({u_adr, u_dat});
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            u_ack <= 1'b0;
            wcnt  <= 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: the six register writes a configuration with divisor d must produce, in order.
    task automatic compare_log(input string nm, input logic [15:0] d);
        logic [10:0] e[$];
        e.push_back({3'd3, 8'h83});
        e.push_back({3'd0, d[7:0]});
        e.push_back({3'd1, d[15:8]});
        e.push_back({3'd3, 8'h03});
        e.push_back({3'd2, 8'h07});
        e.push_back({3'd1, 8'h01});
        check($sformatf("%s_len", nm), 32'(wlog.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < wlog.size()) check($sformatf("%s_wr%0d", nm, i), 32'(wlog[i]), 32'(e[i]));
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic cfg(input logic [15:0] d);
        cfg_start = 1'b1;
        div       = d;
        @(negedge clk);
        cfg_start = 1'b0;
        div       = 16'($urandom);
    endtask

    task automatic host_xfer(input logic [2:0] a, input logic w, input logic [7:0] d,
                             output logic [7:0] rd, output logic [2:0] ua, output int k);
        h_adr = a; h_we = w; h_dat = d; h_sel = 1'b1; h_cyc = 1'b1; h_stb = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!h_ack && k < 500);
        check("host_ack", 32'(h_ack), 32'd1);
        rd = h_rdat;
        ua = u_adr;
        h_cyc = 1'b0; h_stb = 1'b0; h_we = 1'b0; h_sel = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n, k;
        logic [7:0]  rd;
        logic [2:0]  ua, ra;
        logic [7:0]  rdat;
        logic [15:0] d;

        vectors = 0; miscompares = 0;
        ack_dly = 1; wcnt = 0; suppress = 1'b0; u_ack = 1'b0;
        arst_n = 1'b0; cfg_start = 1'b0; div = '0;
        h_adr = '0; h_dat = '0; h_sel = 1'b0; h_we = 1'b0; h_cyc = 1'b0; h_stb = 1'b0;

        cfg_tab[0] = '{16'h0364, 1, 18};
        cfg_tab[1] = '{16'hABCD, 2, 24};
        cfg_tab[2] = '{16'h0001, 3, 30};
        cfg_tab[3] = '{16'hFFFF, 1, 18};

        host_tab[0] = '{3'd5, 1'b0, 8'h00, 8'h60};
        host_tab[1] = '{3'd0, 1'b1, 8'h55, 8'h00};
        host_tab[2] = '{3'd3, 1'b0, 8'h00, 8'hA3};
        host_tab[3] = '{3'd7, 1'b1, 8'hAA, 8'h00};
        host_tab[4] = '{3'd7, 1'b0, 8'h00, 8'hA7};

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_cyc",  32'(u_cyc),  32'd0);
        check("rst_stb",  32'(u_stb),  32'd0);
        check("rst_we",   32'(u_we),   32'd0);
        check("rst_sel",  32'(u_sel),  32'd0);
        check("rst_adr",  32'(u_adr),  32'd0);
        check("rst_dat",  32'(u_dat),  32'd0);
        check("rst_hack", 32'(h_ack),  32'd0);
        check("rst_hdat", 32'(h_rdat), 32'd0);
        check("rst_err",  32'(err),    32'd0);
        check("rst_busy", 32'(busy),   32'd1);

        // Boot sequence with a host LSR read stalled until the port is handed over.
        arst_n = 1'b1;
        fork
            wait_idle(n);
            host_xfer(3'd5, 1'b0, 8'h00, rd, ua, k);
        join
        check("boot_cycles", 32'(n), 32'd18);
        compare_log("boot", 16'd27);
        check("boot_hread_wait", 32'(k), 32'd19);
        check("boot_hread_dat", 32'(rd), 32'h60);
        check("boot_hread_adr", 32'(ua), 32'd5);

        // Table: reconfiguration with host idle, various divisors and ack latencies.
        for (int i = 0; i < 4; i++) begin
            ack_dly = cfg_tab[i].dly;
            wlog.delete();
            cfg(cfg_tab[i].div);
            wait_idle(n);
            check($sformatf("cfg%0d_cycles", i), 32'(n), 32'(cfg_tab[i].cyc));
            compare_log($sformatf("cfg%0d", i), cfg_tab[i].div);
            check($sformatf("cfg%0d_busy", i), 32'(busy), 32'd0);
        end

        // Table: host passthrough reads and writes.
        ack_dly = 2;
        for (int i = 0; i < 5; i++) begin
            wlog.delete();
            host_xfer(host_tab[i].adr, host_tab[i].we, host_tab[i].wdat, rd, ua, k);
            check($sformatf("host%0d_adr", i), 32'(ua), 32'(host_tab[i].adr));
            if (host_tab[i].we) begin
                check($sformatf("host%0d_wlen", i), 32'(wlog.size()), 32'd1);
                if (wlog.size() > 0)
                    check($sformatf("host%0d_wr", i), 32'(wlog[0]), 32'({host_tab[i].adr, host_tab[i].wdat}));
            end else begin
                check($sformatf("host%0d_rd", i), 32'(rd), 32'(host_tab[i].rexp));
            end
        end

        // cfg_start during a running sequence must be ignored.
        ack_dly = 1;
        wlog.delete();
        cfg(16'h1111);
        repeat (4) @(negedge clk);
        cfg(16'h2222);
        wait_idle(n);
        compare_log("ignore", 16'h1111);

        // cfg_start while a host write is open: host finishes, then PEND -> sequence.
        ack_dly = 3;
        wlog.delete();
        h_adr = 3'd4; h_dat = 8'h0B; h_we = 1'b1; h_sel = 1'b1; h_cyc = 1'b1; h_stb = 1'b1;
        @(negedge clk);
        cfg(16'h0203);
        check("pend_busy", 32'(busy), 32'd1);
        check("pend_fwd_cyc", 32'(u_cyc), 32'd1);
        check("pend_fwd_adr", 32'(u_adr), 32'd4);
        k = 0;
        while (!h_ack && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("pend_host_ack", 32'(h_ack), 32'd1);
        check("pend_host_wlen", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) check("pend_host_wr", 32'(wlog[0]), 32'({3'd4, 8'h0B}));
        wlog.delete();
        h_cyc = 1'b0; h_stb = 1'b0; h_we = 1'b0; h_sel = 1'b0;
        @(negedge clk);
        check("pend_issue_stb", 32'(u_stb), 32'd0);
        check("pend_issue_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("pend_first_stb", 32'(u_stb), 32'd1);
        check("pend_first_wr", 32'({u_adr, u_dat}), 32'({3'd3, 8'h83}));
        wait_idle(n);
        compare_log("pend", 16'h0203);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 24; it++) begin
            int unsigned act;
            act = $urandom_range(0, 2);
            if (act == 0) begin
                ack_dly = $urandom_range(1, 3);
                ra = 3'($urandom);
                host_xfer(ra, 1'b0, 8'h00, rdat, ua, k);
                check($sformatf("rnd%0d_rd", it), 32'(rdat), 32'((ra == 3'd5) ? 8'h60 : (8'hA0 | {5'd0, ra})));
            end else if (act == 1) begin
                ack_dly = $urandom_range(1, 3);
                ra = 3'($urandom);
                rdat = 8'($urandom);
                wlog.delete();
                host_xfer(ra, 1'b1, rdat, rd, ua, k);
                check($sformatf("rnd%0d_wlen", it), 32'(wlog.size()), 32'd1);
                if (wlog.size() > 0) check($sformatf("rnd%0d_wr", it), 32'(wlog[0]), 32'({ra, rdat}));
            end else begin
                bit twice;
                ack_dly = $urandom_range(1, 3);
                d = 16'($urandom);
                twice = 1'($urandom_range(0, 1));
                wlog.delete();
                cfg(d);
                if (twice) begin
                    repeat ($urandom_range(0, 8)) @(negedge clk);
                    cfg(d ^ 16'h5A5A);
                end
                wait_idle(n);
                if (!twice) check($sformatf("rnd%0d_cycles", it), 32'(n), 32'(6 * (2 + ack_dly)));
                compare_log($sformatf("rnd%0d", it), d);
            end
        end

        // Reset pulse during step 3 aborts and restarts with the reset divisor.
        ack_dly = 1;
        cfg(16'h0777);
        k = 0;
        while (!(u_stb && u_adr == 3'd3 && u_dat == 8'h03) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("mid_rst_reach", 32'(k < 200), 32'd1);
        arst_n = 1'b0;
        #1;
        check("mid_rst_cyc",  32'(u_cyc), 32'd0);
        check("mid_rst_stb",  32'(u_stb), 32'd0);
        check("mid_rst_adr",  32'(u_adr), 32'd0);
        check("mid_rst_dat",  32'(u_dat), 32'd0);
        check("mid_rst_busy", 32'(busy),  32'd1);
        @(negedge clk);
        @(negedge clk);
        wlog.delete();
        arst_n = 1'b1;
        wait_idle(n);
        check("mid_rst_cycles", 32'(n), 32'd18);
        compare_log("mid_rst", 16'd27);

`ifdef UART_INIT_ACK_TIMEOUT_EN
        // Ack withheld at step 2: timeout flags err_o and hands the port back.
        wlog.delete();
        cfg(16'h0102);
        k = 0;
        while (wlog.size() < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        suppress = 1'b1;
        wait_idle(n);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_wlen", 32'(wlog.size()), 32'd2);
        check("tmo_wait", 32'(n >= 255), 32'd1);
        suppress = 1'b0;
        wlog.delete();
        cfg(16'h0102);
        check("tmo_err_clr", 32'(err), 32'd0);
        wait_idle(n);
        compare_log("tmo_rerun", 16'h0102);
`else
        check("err_tied", 32'(err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
